// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: FSM encoding and width constants shared by the RAM controller files.
package ram_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP, S_BURST} state_t;
  localparam int BURST_LEN = 4;
  localparam int WORD_W = 32;
  localparam int BE_W = WORD_W / 8;
endpackage

// File: rtl/ram_ctrl_array.sv
// ram_ctrl_array: single-port word array with synchronous read and byte-enable writes.
module ram_ctrl_array
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/ram_controller.sv
// ram_controller: wait-stated RAM controller behind a valid/ready request port.
// Define RAM_CTRL_BURST_EN to enable 4-beat critical-word-first wrapping read bursts.
module ram_controller
  import ram_ctrl_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  input  logic              req_burst,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_last
);
  localparam int OFS_W = $clog2(BURST_LEN);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  state_t state;
  logic [3:0] wcnt;
  logic [OFS_W-1:0] ofs;
  logic [ADDR_W-1:0] idx_q, raddr;
  logic [WORD_W-1:0] off, wdata_q, dout;
  logic [BE_W-1:0] be_q;
  logic write_q, err_q, burst_q, bad, burst_in, more;
  assign off = req_addr - BASE_ADDR;
`ifdef RAM_CTRL_BURST_EN
  assign burst_in = req_burst;
  assign bad = |req_addr[1:0] || |(off >> (ADDR_W + 2)) || (req_burst && req_write);
`else
  logic unused_burst;
  assign unused_burst = req_burst;
  assign burst_in = 1'b0;
  assign bad = |req_addr[1:0] || |(off >> (ADDR_W + 2));
`endif
  // ofs walks the beats; the low index bits wrap inside the aligned 4-word block
  assign raddr = {idx_q[ADDR_W-1:2], idx_q[1:0] + ofs};
  assign more = state == S_RESP ? burst_q && !err_q : ofs != '0;
  ram_ctrl_array #(.ADDR_W(ADDR_W)) u_array (
    .clk,
    .we   (state == S_ACCESS && write_q && !err_q && !rst),
    .addr (raddr),
    .wdata(wdata_q),
    .be   (be_q),
    .rdata(dout)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      rsp_last <= 1'b0;
      wcnt <= '0;
      ofs <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      rsp_last <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            state <= WAIT_CYCLES == 0 ? S_ACCESS : S_WAIT;
            req_ready <= 1'b0;
            wcnt <= '0;
            ofs <= '0;
            idx_q <= off[ADDR_W+1:2];
            write_q <= req_write;
            wdata_q <= req_wdata;
            be_q <= req_be;
            burst_q <= burst_in;
            err_q <= bad;
          end else req_ready <= 1'b1;
        end
        S_WAIT: begin
          wcnt <= wcnt + 4'd1;
          if (wcnt == WAIT_LAST) state <= S_ACCESS;
        end
        S_ACCESS: begin
          state <= S_RESP;
          ofs <= ofs + OFS_W'(1);
        end
        S_RESP, S_BURST: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= write_q || err_q ? '0 : dout;
          rsp_err <= err_q;
          ofs <= ofs + OFS_W'(1);
          state <= more ? S_BURST : S_IDLE;
          req_ready <= !more;
          rsp_last <= !more;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_controller.sv
// tb_ram_controller: scoreboard bench for ram_controller (default build and RAM_CTRL_BURST_EN).
module tb_ram_controller;
  localparam int ADDR_W = 12;
  localparam int WAIT_CYCLES = 2;
  localparam logic [31:0] BASE_ADDR = 32'h0;
  localparam int LAT = WAIT_CYCLES + 2;
  localparam logic [31:0] LIMIT = 32'd4 << ADDR_W;
  typedef struct {logic [31:0] d; logic e; logic l; int c;} exp_t;
  logic clk = 0, rst = 1, req_valid = 0, req_write = 0, req_burst = 0;
  logic req_ready, rsp_valid, rsp_err, rsp_last;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata;
  logic [3:0] req_be = 0;
  int cyc = 0, checks = 0, errors = 0, pulses = 0;
  exp_t sb[$];

  ram_controller #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .req_burst(req_burst),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_last(rsp_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        pulses++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp rdata=%h err=%b last=%b cyc=%0d, none expected", rsp_rdata, rsp_err, rsp_last, cyc);
        end else begin
          e = sb.pop_front();
          if (rsp_rdata !== e.d || rsp_err !== e.e || rsp_last !== e.l || cyc != e.c) begin
            errors++;
            $display("FAIL rsp got rdata=%h err=%b last=%b cyc=%0d, want rdata=%h err=%b last=%b cyc=%0d",
                     rsp_rdata, rsp_err, rsp_last, cyc, e.d, e.e, e.l, e.c);
          end
        end
      end
    end
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic e, input logic l, input int c);
    exp_t x;
    x.d = d; x.e = e; x.l = l; x.c = c;
    sb.push_back(x);
  endtask

  // drives a request, waits for acceptance, then scrambles the inputs to prove they were latched
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic b, input logic keep, output int acc);
    int n = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_be = be; req_burst = b;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout addr=%h ready=%b, want 1", a, req_ready);
    end
    @(negedge clk);
    acc = cyc;
    req_valid = keep; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    req_write = ~w; req_burst = 0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic e);
    int acc;
    issue(1'b0, a, 32'h0, 4'h0, 1'b0, 1'b0, acc);
    expect_rsp(e ? 32'h0 : d, e, 1'b1, acc + LAT);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic e);
    int acc;
    issue(1'b1, a, d, be, 1'b0, 1'b0, acc);
    expect_rsp(32'h0, e, 1'b1, acc + LAT);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_rsp pending=%0d, want 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_last} !== 4'b0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b valid=%b err=%b last=%b rdata=%h, want all 0",
               req_ready, rsp_valid, rsp_err, rsp_last, rsp_rdata);
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b, want 1", req_ready);
    end
  endtask

  task automatic test_basic();
    wr(32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    rd(32'h10, 32'hDEADBEEF, 1'b0);
    drain("basic");
  endtask

  task automatic test_byte_enables();
    wr(32'h20, 32'h11223344, 4'hF, 1'b0);
    wr(32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
    rd(32'h20, 32'h11BB33DD, 1'b0);
    wr(32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0);
    rd(32'h20, 32'h11BB33DD, 1'b0);
    drain("byte_enables");
  endtask

  task automatic test_errors();
    rd(32'h13, 32'h0, 1'b1);
    rd(BASE_ADDR + LIMIT, 32'h0, 1'b1);
    rd(32'hFFFFFFFC, 32'h0, 1'b1);
    wr(32'h22, 32'h12345678, 4'hF, 1'b1);
    rd(32'h20, 32'h11BB33DD, 1'b0);
    wr(32'h0, 32'h0000AAAA, 4'hF, 1'b0);
    wr(BASE_ADDR + LIMIT, 32'h00000BAD, 4'hF, 1'b1);
    rd(32'h0, 32'h0000AAAA, 1'b0);
    wr(LIMIT - 4, 32'hCAFEF00D, 4'hF, 1'b0);
    rd(LIMIT - 4, 32'hCAFEF00D, 1'b0);
    rd(32'h10, 32'hDEADBEEF, 1'b0);
    drain("errors");
  endtask

  task automatic test_back_to_back();
    int a1, a2, a3, p;
    p = pulses;
    issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1, a1);
    expect_rsp(32'hDEADBEEF, 1'b0, 1'b1, a1 + LAT);
    issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b1, a2);
    expect_rsp(32'h11BB33DD, 1'b0, 1'b1, a2 + LAT);
    issue(1'b0, LIMIT - 4, 32'h0, 4'h0, 1'b0, 1'b0, a3);
    expect_rsp(32'hCAFEF00D, 1'b0, 1'b1, a3 + LAT);
    drain("back_to_back");
    checks++;
    if (a2 - a1 != WAIT_CYCLES + 3 || a3 - a2 != WAIT_CYCLES + 3) begin
      errors++;
      $display("FAIL b2b_accept_spacing got %0d,%0d, want %0d", a2 - a1, a3 - a2, WAIT_CYCLES + 3);
    end
    checks++;
    if (pulses - p != 3) begin
      errors++;
      $display("FAIL b2b_pulse_count got %0d, want 3", pulses - p);
    end
  endtask

  task automatic test_reset_midop();
    int acc, p;
    wr(32'h30, 32'h5, 4'hF, 1'b0);
    drain("midop_setup");
    p = pulses;
    issue(1'b1, 32'h30, 32'h99, 4'hF, 1'b0, 1'b0, acc);
    rst = 1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset_outputs ready=%b valid=%b, want 0 0", req_ready, rsp_valid);
    end
    @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    issue(1'b1, 32'h30, 32'h77, 4'hF, 1'b0, 1'b0, acc);
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (8) @(negedge clk);
    checks++;
    if (pulses != p) begin
      errors++;
      $display("FAIL midop_no_rsp got %0d pulses, want 0", pulses - p);
    end
    rd(32'h30, 32'h5, 1'b0);
    drain("midop");
  endtask

  task automatic test_burst();
    int acc;
    for (int k = 0; k < 4; k++) wr(32'h40 + 4 * k, k, 4'hF, 1'b0);
    drain("burst_setup");
`ifdef RAM_CTRL_BURST_EN
    issue(1'b0, 32'h48, 32'h0, 4'h0, 1'b1, 1'b0, acc);
    expect_rsp(32'd2, 1'b0, 1'b0, acc + LAT);
    expect_rsp(32'd3, 1'b0, 1'b0, acc + LAT + 1);
    expect_rsp(32'd0, 1'b0, 1'b0, acc + LAT + 2);
    expect_rsp(32'd1, 1'b0, 1'b1, acc + LAT + 3);
    drain("burst_read");
    issue(1'b1, 32'h40, 32'hFFFF, 4'hF, 1'b1, 1'b0, acc);
    expect_rsp(32'h0, 1'b1, 1'b1, acc + LAT);
    issue(1'b0, 32'h4A, 32'h0, 4'h0, 1'b1, 1'b0, acc);
    expect_rsp(32'h0, 1'b1, 1'b1, acc + LAT);
    rd(32'h40, 32'd0, 1'b0);
`else
    issue(1'b0, 32'h48, 32'h0, 4'h0, 1'b1, 1'b0, acc);
    expect_rsp(32'd2, 1'b0, 1'b1, acc + LAT);
    issue(1'b1, 32'h40, 32'h9, 4'hF, 1'b1, 1'b0, acc);
    expect_rsp(32'h0, 1'b0, 1'b1, acc + LAT);
    rd(32'h40, 32'h9, 1'b0);
`endif
    drain("burst");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_byte_enables();
    test_errors();
    test_back_to_back();
    test_reset_midop();
    test_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
